// File: rtl/aks_ise.sv
// AES key-schedule ISE: computes SubWord(RotWord(w)) ^ Rcon using one shared S-box over four cycles,
// with two-byte operand loads and one-byte result reads.
module aks_ise #(
  parameter logic [7:0] RCON_INIT = 8'h01,
  parameter logic [7:0] RCON_LAST = 8'h36
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] sr,
  output logic [7:0] sr_out,
  output logic [7:0] result,
  output logic       wait_req
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [2:0] phase_r;
  logic       busy_r;
  logic [1:0] step_r;
  logic [7:0] w0_r, w1_r, w2_r, w3_r;
  logic [7:0] t0_r, t1_r, t2_r, t3_r;
  logic [7:0] rcon_r;
  logic [7:0] result_r;
  logic [7:0] sr_out_r;
  logic       honour_s;
  logic [7:0] sbox_in_s;
  logic [7:0] sbox_out_s;
  logic [7:0] rcon_next_s;

  assign result   = result_r;
  assign sr_out   = sr_out_r;
  assign wait_req = busy_r;

  // Start qualification, S-box operand select (RotWord order) and next Rcon
  always_comb begin
    honour_s  = start & ~busy_r;
    sbox_in_s = w0_r;
    case (step_r)
      2'd0:    sbox_in_s = w0_r;
      2'd1:    sbox_in_s = w3_r;
      2'd2:    sbox_in_s = w2_r;
      2'd3:    sbox_in_s = w1_r;
      default: sbox_in_s = w0_r;
    endcase
    sbox_out_s = SBOX[sbox_in_s];
    if (rcon_r == RCON_LAST) begin
      rcon_next_s = RCON_INIT;
    end else begin
      rcon_next_s = {rcon_r[6:0], 1'b0} ^ (rcon_r[7] ? 8'h1b : 8'h00);
    end
  end

  // Instruction phases, four-cycle lookup sequence and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r  <= 3'd0;
      busy_r   <= 1'b0;
      step_r   <= 2'd0;
      w0_r     <= 8'h00;
      w1_r     <= 8'h00;
      w2_r     <= 8'h00;
      w3_r     <= 8'h00;
      t0_r     <= 8'h00;
      t1_r     <= 8'h00;
      t2_r     <= 8'h00;
      t3_r     <= 8'h00;
      rcon_r   <= RCON_INIT;
      result_r <= 8'h00;
      sr_out_r <= 8'h00;
    end else begin
      if (busy_r) begin
        step_r <= step_r + 2'd1;
        case (step_r)
          2'd0: t3_r <= sbox_out_s;
          2'd1: t2_r <= sbox_out_s;
          2'd2: t1_r <= sbox_out_s;
          2'd3: begin
            t0_r   <= sbox_out_s ^ rcon_r;
            busy_r <= 1'b0;
            rcon_r <= rcon_next_s;
          end
          default: busy_r <= 1'b0;
        endcase
      end
      if (honour_s) begin
        phase_r <= (phase_r >= 3'd5) ? 3'd0 : phase_r + 3'd1;
        // Reads keep the "last round" flag captured when the computation started
        sr_out_r <= {sr[7:2], sr_out_r[1], sr[0]};
        case (phase_r)
          3'd0: begin
            w0_r     <= a;
            w1_r     <= b;
            sr_out_r <= sr;
            if (sr[0]) begin
              rcon_r <= RCON_INIT;
            end
          end
          3'd1: begin
            w2_r     <= a;
            w3_r     <= b;
            busy_r   <= 1'b1;
            step_r   <= 2'd0;
            sr_out_r <= {sr[7:2], (rcon_r == RCON_LAST), sr[0]};
          end
          3'd2:    result_r <= t3_r;
          3'd3:    result_r <= t2_r;
          3'd4:    result_r <= t1_r;
          3'd5:    result_r <= t0_r;
          default: sr_out_r <= sr;
        endcase
      end
    end
  end

endmodule

// File: doc/aks_ise.md
Name: aks_ise

Overview:
- AES key-schedule instruction set extension for the 8-bit core; computes the per-round key-expansion temp word SubWord(RotWord(w)) xor Rcon.
- Input word w = {w0,w1,w2,w3} is loaded two bytes per instruction.
- Results are read back one byte per instruction, in the same start/wait_req protocol and byte order used by the neighbouring column ISE, so round-key bytes feed that stage and the AddRoundKey path directly.
- Single shared S-box lookup, time-multiplexed over 4 cycles; internal Rcon register tracks the round.

Parameters:
- RCON_INIT, 8'h01, Rcon value after reset or schedule restart
- RCON_LAST, 8'h36, final-round Rcon; after use, Rcon wraps to RCON_INIT

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle instruction strobe
- a  input  8  first operand byte
- b  input  8  second operand byte
- sr  input  8  processor status register in
- sr_out  output  8  status register out (registered)
- result  output  8  result byte (registered)
- wait_req  output  1  high while busy; processor stalls

Behaviour:
- Reset (rst=1 at an edge): result=8'h00, sr_out=8'h00, wait_req=0, phase=0, rcon=RCON_INIT, w/t registers cleared. Reset mid-computation aborts it; no partial results are retained.
- A start is honoured only when wait_req=0; a start during wait_req=1 is ignored.
- phase counter 0..5 advances on each honoured start, wrapping 5 -> 0.
- Phase 0 (load lo):
  - w0<=a, w1<=b.
  - If sr[0]=1, rcon<=RCON_INIT before this round's use.
  - wait_req stays 0.
- Phase 1 (load hi + compute):
  - w2<=a, w3<=b; wait_req<=1 at the same edge.
  - The next 4 cycles perform one S-box lookup each: t3=S(w0), t2=S(w3), t1=S(w2), t0=S(w1)^rcon.
  - Edge 4 after the start: wait_req<=0 and rcon advances.
    - If rcon==RCON_LAST: rcon<=RCON_INIT.
    - Otherwise: rcon<=xtime(rcon), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
  - Total busy time is exactly 4 cycles.
- Phases 2,3,4,5 (read): result<=t3, t2, t1, t0 respectively at the start edge. wait_req stays 0. result holds until the next read or reset.
- sr_out: at every honoured start, sr_out<=sr, except sr_out[1] as follows:
  - Phase 1 start: sr_out[1] is set when the rcon used in that computation equals RCON_LAST.
  - Phases 2..5: sr_out[1] keeps its phase-1 value.
  - Phase 0: sr_out[1] = sr[1] (normal passthrough).
- S-box: standard FIPS-197 forward S-box, combinational table, one lookup per cycle.
- Simultaneous rst and start: rst wins.

Test Plan:
- FIPS-197 key, w=09cf4f3c: start(a=09,b=cf), start(a=4f,b=3c); wait_req=1 for 4 cycles; four reads -> result 01, eb, 84, 8b.
- Continue without reset, w=2a6c7605: uses rcon 02 -> reads e5, 6b, 38, 52.
- Restart: load 09cf4f3c with sr=8'h01 on the first load start -> reads 01, eb, 84, 8b again; sr_out[7:2,0] equals the sr presented at each start.
- Ten back-to-back rounds on w=00000000:
  - Round-1 reads are 63, 63, 63, 62; round k's last read is 63^rcon_k.
  - rcon sequence is 01,02,04,08,10,20,40,80,1b,36; sr_out[1]=1 only in round 10.
  - Round 11 uses rcon 01 again.
- Start asserted while wait_req=1 -> ignored; phase, result and rcon are unchanged, and reads still return the correct bytes.
- Assert rst during the 2nd busy cycle -> next cycle wait_req=0, result=00, sr_out=00; a fresh load of 09cf4f3c reads 01, eb, 84, 8b (rcon back to 01).
